// File: rtl/glitch_scheduler.sv
// glitch_scheduler
//   Owns the 8-bit core-rail DAC. Normally forwards core_dac one registered
//   cycle late. Once armed and triggered it waits cfg_offset cycles, then
//   drives a glitch level for cfg_width cycles. This repeats cfg_repeat times,
//   with cfg_gap cycles at core level between pulses, and then hands the DAC
//   back to core_dac.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   core_dac          DAC code requested by pmic_core
//   cfg_offset/width/gap/level/repeat
//                     sequence configuration, latched on arm
//   arm               latch config and enter ARMED (IDLE only)
//   disarm            abort to IDLE from any state (highest priority)
//   trigger           start the sequence (ARMED only), level-sampled
//   dac_out           registered DAC code
//   glitch_active     high while dac_out holds the glitch level
//   busy              high in any state other than IDLE
//   done              one-cycle pulse after the final pulse
//   state             FSM state (debug)
module glitch_scheduler #(
  parameter int unsigned OFF_W       = 32,
  parameter int unsigned WID_W       = 16,
  parameter int unsigned CNT_W       = 8,
  parameter logic [7:0]  LEVEL_FLOOR = 8'h10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       core_dac,
  input  logic [OFF_W-1:0] cfg_offset,
  input  logic [WID_W-1:0] cfg_width,
  input  logic [WID_W-1:0] cfg_gap,
  input  logic [7:0]       cfg_level,
  input  logic [CNT_W-1:0] cfg_repeat,
  input  logic             arm,
  input  logic             disarm,
  input  logic             trigger,
  output logic [7:0]       dac_out,
  output logic             glitch_active,
  output logic             busy,
  output logic             done,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_OFFSET = 3'd2,
    S_PULSE  = 3'd3,
    S_GAP    = 3'd4
  } state_t;

  state_t           state_q;
  logic [OFF_W-1:0] off_q, off_cnt_q;
  logic [WID_W-1:0] wid_q, gap_q, wid_cnt_q, gap_cnt_q;
  logic [7:0]       lvl_q, dac_q;
  logic [CNT_W-1:0] left_q;
  logic             glitch_q, last_q, done_q;

  // Config after zero-to-one and floor substitutions
  logic [WID_W-1:0] wid_d, gap_d;
  logic [7:0]       lvl_d;
  logic [CNT_W-1:0] rep_d;

  always_comb begin
    wid_d = (cfg_width == '0) ? WID_W'(1) : cfg_width;
    gap_d = (cfg_gap == '0) ? WID_W'(1) : cfg_gap;
    lvl_d = (cfg_level < LEVEL_FLOOR) ? LEVEL_FLOOR : cfg_level;
    rep_d = (cfg_repeat == '0) ? CNT_W'(1) : cfg_repeat;
  end

  // dac_out/glitch_active are computed from the state being left, so a
  // PULSE entered at edge n shows the level from edge n+1 onwards. done is
  // delayed one extra cycle through last_q so it coincides with the first
  // post-pulse core value on dac_out.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      off_q     <= '0;
      wid_q     <= '0;
      gap_q     <= '0;
      lvl_q     <= '0;
      left_q    <= '0;
      off_cnt_q <= '0;
      wid_cnt_q <= '0;
      gap_cnt_q <= '0;
      dac_q     <= '0;
      glitch_q  <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      last_q   <= 1'b0;
      done_q   <= last_q & ~disarm;
      dac_q    <= core_dac;
      glitch_q <= 1'b0;
      if (disarm) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (arm) begin
              off_q   <= cfg_offset;
              wid_q   <= wid_d;
              gap_q   <= gap_d;
              lvl_q   <= lvl_d;
              left_q  <= rep_d;
              state_q <= S_ARMED;
            end
          end
          S_ARMED: begin
            if (trigger) begin
              if (off_q == '0) begin
                wid_cnt_q <= wid_q - WID_W'(1);
                state_q   <= S_PULSE;
              end else begin
                off_cnt_q <= off_q - OFF_W'(1);
                state_q   <= S_OFFSET;
              end
            end
          end
          S_OFFSET: begin
            if (off_cnt_q == '0) begin
              wid_cnt_q <= wid_q - WID_W'(1);
              state_q   <= S_PULSE;
            end else begin
              off_cnt_q <= off_cnt_q - OFF_W'(1);
            end
          end
          S_PULSE: begin
            dac_q    <= lvl_q;
            glitch_q <= 1'b1;
            if (wid_cnt_q == '0) begin
              if (left_q > CNT_W'(1)) begin
                left_q    <= left_q - CNT_W'(1);
                gap_cnt_q <= gap_q - WID_W'(1);
                state_q   <= S_GAP;
              end else begin
                last_q  <= 1'b1;
                state_q <= S_IDLE;
              end
            end else begin
              wid_cnt_q <= wid_cnt_q - WID_W'(1);
            end
          end
          S_GAP: begin
            if (gap_cnt_q == '0) begin
              wid_cnt_q <= wid_q - WID_W'(1);
              state_q   <= S_PULSE;
            end else begin
              gap_cnt_q <= gap_cnt_q - WID_W'(1);
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign dac_out       = dac_q;
  assign glitch_active = glitch_q;
  assign done          = done_q;
  assign busy          = (state_q != S_IDLE);
  assign state         = state_q;

endmodule

// File: tb/tb_glitch_scheduler.sv
module tb_glitch_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  core_dac;
  logic [31:0] cfg_offset;
  logic [15:0] cfg_width, cfg_gap;
  logic [7:0]  cfg_level, cfg_repeat;
  logic        arm, disarm, trigger;
  logic [7:0]  dac_out;
  logic        glitch_active, busy, done;
  logic [2:0]  state;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  glitch_scheduler #(.OFF_W(32), .WID_W(16), .CNT_W(8), .LEVEL_FLOOR(8'h10)) dut (
    .clk(clk), .reset(reset), .core_dac(core_dac),
    .cfg_offset(cfg_offset), .cfg_width(cfg_width), .cfg_gap(cfg_gap),
    .cfg_level(cfg_level), .cfg_repeat(cfg_repeat),
    .arm(arm), .disarm(disarm), .trigger(trigger),
    .dac_out(dac_out), .glitch_active(glitch_active), .busy(busy),
    .done(done), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; outputs are then sampled 1 ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic config_arm(input logic [31:0] off, input logic [15:0] wid,
                            input logic [15:0] gap, input logic [7:0] lvl,
                            input logic [7:0] rep);
    cfg_offset = off; cfg_width = wid; cfg_gap = gap;
    cfg_level = lvl;  cfg_repeat = rep;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    cfg_offset = '0; cfg_width = '0; cfg_gap = '0; cfg_level = '0; cfg_repeat = '0;
  endtask

  // Sequence 1 (offset 3, width 2, level 0x40, core 0x80); optionally tries
  // to re-arm with different config during OFFSET, which must be ignored.
  task automatic run_seq1(input bit rearm, input string pfx);
    logic [7:0] exp_dac;
    config_arm(32'd3, 16'd2, 16'd1, 8'h40, 8'd1);
    check({pfx, "_armed_state"}, 32'(state), 32'd1);
    check({pfx, "_armed_busy"}, 32'(busy), 32'd1);
    trigger = 1'b1;
    tick();                       // edge k
    trigger = 1'b0;
    check({pfx, "_k_state"}, 32'(state), 32'd2);
    for (int n = 1; n <= 7; n++) begin
      if (rearm && n == 1) begin
        cfg_offset = 32'd0; cfg_width = 16'd5; cfg_level = 8'h20; cfg_repeat = 8'd4;
        arm = 1'b1;
      end
      tick();                     // edge k+n
      arm = 1'b0;
      exp_dac = (n == 4 || n == 5) ? 8'h40 : 8'h80;
      check($sformatf("%s_dac_k%0d", pfx, n), 32'(dac_out), 32'(exp_dac));
      check($sformatf("%s_glitch_k%0d", pfx, n), 32'(glitch_active), (n == 4 || n == 5) ? 32'd1 : 32'd0);
      check($sformatf("%s_done_k%0d", pfx, n), 32'(done), (n == 6) ? 32'd1 : 32'd0);
    end
    check({pfx, "_end_state"}, 32'(state), 32'd0);
    check({pfx, "_end_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int done_cnt;
    reset = 1'b1; core_dac = 8'h80; arm = 1'b0; disarm = 1'b0; trigger = 1'b0;
    cfg_offset = '0; cfg_width = '0; cfg_gap = '0; cfg_level = '0; cfg_repeat = '0;
    tick(); tick();
    check("rst_dac", 32'(dac_out), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_glitch", 32'(glitch_active), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();
    check("idle_dac_passthru", 32'(dac_out), 32'h80);

    // 1: basic single pulse with offset
    run_seq1(1'b0, "t1");

    // 2: offset 0, width 0 -> 1, level clamped up to floor, repeat 0 -> 1
    config_arm(32'd0, 16'd0, 16'd0, 8'h05, 8'd0);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    check("t2_k_state", 32'(state), 32'd3);
    tick();
    check("t2_dac_k1", 32'(dac_out), 32'h10);
    check("t2_glitch_k1", 32'(glitch_active), 32'd1);
    check("t2_done_k1", 32'(done), 32'd0);
    tick();
    check("t2_dac_k2", 32'(dac_out), 32'h80);
    check("t2_done_k2", 32'(done), 32'd1);
    check("t2_state_k2", 32'(state), 32'd0);

    // 3: three 2-cycle pulses, gap 4, offset 1
    config_arm(32'd1, 16'd2, 16'd4, 8'h30, 8'd3);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    done_cnt = 0;
    for (int n = 1; n <= 17; n++) begin
      bit in_p;
      tick();
      in_p = (n == 2 || n == 3 || n == 8 || n == 9 || n == 14 || n == 15);
      check($sformatf("t3_dac_k%0d", n), 32'(dac_out), in_p ? 32'h30 : 32'h80);
      check($sformatf("t3_glitch_k%0d", n), 32'(glitch_active), in_p ? 32'd1 : 32'd0);
      check($sformatf("t3_done_k%0d", n), 32'(done), (n == 16) ? 32'd1 : 32'd0);
      if (done) done_cnt++;
    end
    check("t3_done_count", 32'(done_cnt), 32'd1);

    // 4: disarm on the 2nd cycle of a width-10 pulse
    config_arm(32'd0, 16'd10, 16'd1, 8'h40, 8'd1);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    tick();
    check("t4_dac_k1", 32'(dac_out), 32'h40);
    disarm = 1'b1;
    tick();
    disarm = 1'b0;
    check("t4_dac_disarm", 32'(dac_out), 32'h80);
    check("t4_busy_disarm", 32'(busy), 32'd0);
    check("t4_state_disarm", 32'(state), 32'd0);
    check("t4_glitch_disarm", 32'(glitch_active), 32'd0);
    done_cnt = 0;
    for (int n = 0; n < 14; n++) begin
      tick();
      if (done || glitch_active) done_cnt++;
    end
    check("t4_no_done_after_disarm", 32'(done_cnt), 32'd0);

    // 5: arm+disarm together, trigger in IDLE, re-arm during OFFSET
    cfg_offset = 32'd3; cfg_width = 16'd2; cfg_level = 8'h40; cfg_repeat = 8'd1;
    arm = 1'b1; disarm = 1'b1;
    tick();
    arm = 1'b0; disarm = 1'b0;
    check("t5_arm_disarm_state", 32'(state), 32'd0);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    check("t5_trig_idle_state", 32'(state), 32'd0);
    tick();
    run_seq1(1'b1, "t5");

    // 6a: core_dac change during PULSE appears right after the pulse
    config_arm(32'd0, 16'd4, 16'd1, 8'h40, 8'd1);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    tick();
    check("t6_dac_k1", 32'(dac_out), 32'h40);
    core_dac = 8'h90;
    for (int n = 2; n <= 4; n++) begin
      tick();
      check($sformatf("t6_dac_k%0d", n), 32'(dac_out), 32'h40);
    end
    tick();
    check("t6_dac_post", 32'(dac_out), 32'h90);
    check("t6_done_post", 32'(done), 32'd1);

    // 6b: reset mid-PULSE
    config_arm(32'd0, 16'd4, 16'd1, 8'h40, 8'd1);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    tick();
    check("t6r_dac_k1", 32'(dac_out), 32'h40);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6r_dac", 32'(dac_out), 32'd0);
    check("t6r_state", 32'(state), 32'd0);
    check("t6r_glitch", 32'(glitch_active), 32'd0);
    check("t6r_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
